rtc_bus_responder: RTL and testbench
====================================

# rtc_bus_responder

Synthesizable model of the real-time-clock chip on the far end of the multiplexed address/data bus driven by `Protocolo_rtc`. It decodes the ChipSelect/Write/Read/AoD strobes, latches a register address, accepts register writes and returns register contents on reads. It keeps a BCD calendar clock ticking from a parameterised prescaler. It serves as the bench partner for the protocol master and as a stand-in for the RTC in board bring-up without the chip.

## Interface
Parameters:
- `TICK_DIV`, 100_000_000: clk cycles per one-second tick; minimum 4.

Ports:
- `clk`  in  1  system clock.
- `reset`  in  1  synchronous, active-high.
- `ChipSelect`  in  1  active-low chip select.
- `Write`  in  1  active-low write strobe.
- `Read`  in  1  active-low read strobe.
- `AoD`  in  1  0 = address phase, 1 = data phase.
- `data_in`  in  8  bus value driven by the master; top level ties it to the bidirectional DATA_ADDRESS pad.
- `data_out`  out  8  bus value driven by this block.
- `data_oe`  out  1  1 = this block drives the pad; top level forms the tristate.
- `tick`  out  1  one-cycle pulse on each seconds increment.

## Operation
- Synchronisation: `ChipSelect`, `Write`, `Read` and `AoD` each pass through 2 flops. All edge detection uses the synchronised copies.
- Address latch: a rising edge of synchronised `Write` with CS=0 and AoD=0 loads `addr <= data_in`. `data_in` is sampled at the cycle the edge is detected, through its own 2-flop stage.
- Data write: a rising edge of `Write` with CS=0 and AoD=1 writes `reg[addr] <= data_in` if `addr` is mapped. Unmapped addresses are ignored.
- Data read: a falling edge of `Read` with CS=0 and AoD=1 snapshots `reg[addr]` into `data_out` and sets `data_oe=1`. Unmapped addresses return 0x00. A rising edge of `Read`, or CS going high, clears `data_oe`. `data_out` holds its value.
- Register map (BCD):
  - 0x21 seconds, 00-59.
  - 0x22 minutes, 00-59.
  - 0x23 hours, 00-23.
  - 0x24 day, 01-31; every month has 31 days, a deliberate simplification.
  - 0x25 month, 01-12.
  - 0x26 year, 00-99.
  - 0x20 control: bit0 = run (1 = counting), other bits read 0.
- Prescaler: counts 0..`TICK_DIV`-1 while run=1, frozen while run=0. Wrap asserts `tick` for one cycle.
- Increment on tick:
  - Seconds +1 in BCD.
  - A register equal to or above its maximum wraps to its minimum and carries into the next register.
  - Carries ripple in the same cycle: 23:59:59 on 31/12/99 becomes 00:00:00 on 01/01/00.
  - Low nibble 9 goes to 0 with +1 on the high nibble.
  - Invalid BCD written by the master is stored verbatim; the next increment applies the rules above.
- Collision: if a data-write commit and a tick occur in the same cycle, the write commits and the tick's increment is deferred exactly one cycle through a pending flag. The `tick` output still pulses in the original cycle.
- No handshake back-pressure: the master alone owns strobe timing.

## Timing
- Reset values:
  - Time registers 00, except day=01 and month=01.
  - control=0x01 (run).
  - `addr`=0x00.
  - `data_out`=0x00, `data_oe`=0, `tick`=0.
  - Prescaler = 0.
  - Synchroniser flops reset to inactive: strobes 1, AoD 0.
- Strobe latency: let a pin transition first sample at edge E.
  - Its effect (address latch, write commit, read snapshot with `data_oe`↑, or `data_oe`↓) is visible after edge E+2.
  - The master must hold a strobe low for at least 3 clk and keep `data_in` stable from the strobe fall until 3 clk after its rise.
- Read data is the register value at the snapshot cycle. A tick afterwards does not alter `data_out` during that strobe.
- Reset asserted mid-transaction: everything returns to reset values on the next edge, and `data_oe` drops immediately at that edge. A strobe still held low after reset release produces no action until it has risen and fallen again.
- Strobe edges with CS=1 are ignored. CS rising while `Read` is low clears `data_oe` at E+2.

## Test plan
- Reset with `TICK_DIV`=10 → `data_oe`=0, `data_out`=0x00. Read of 0x21/0x24/0x25 returns 0x00/0x01/0x01. `tick` first pulses 10 clk after reset release.
- Address 0x23, write 0x17; address 0x23, read → `data_out`=0x17, `data_oe`=1 exactly 2 edges after `Read` first samples low, 0 two edges after it rises.
- Write 23:59:59 / day 31 / month 12 / year 99, one tick → reads give 00,00,00,01,01,00.
- Write 0x59 to 0x21 in the same cycle the prescaler wraps → 0x21 reads 0x59 after the commit and 0x00 one cycle later. Minutes have incremented by 1.
- Write 0x00 to 0x20 → no `tick` for 50 clk and seconds unchanged. Write 0x01 → ticks resume every 10 clk.
- Assert `reset` while `Read` is low with `data_oe`=1 → `data_oe`=0 at the next edge and stays 0 until a fresh `Read` fall. Read of unmapped 0x55 returns 0x00.

Source files
------------

// File: rtl/rtc_bus_responder.sv
// RTC chip stand-in for the multiplexed address/data bus: strobe decode,
// register file with a BCD calendar clock driven by a one-second prescaler.
module rtc_bus_responder #(
  parameter int TICK_DIV = 100_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ChipSelect,
  input  logic       Write,
  input  logic       Read,
  input  logic       AoD,
  input  logic [7:0] data_in,
  output logic [7:0] data_out,
  output logic       data_oe,
  output logic       tick
);

  localparam int CW = $clog2(TICK_DIV);
  localparam logic [CW-1:0] CNT_LAST = CW'(TICK_DIV - 1);
  // Time registers in carry order: sec, min, hour, day, month, year
  localparam logic [7:0] TM_LO [6] = '{8'h00, 8'h00, 8'h00, 8'h01, 8'h01, 8'h00};
  localparam logic [7:0] TM_HI [6] = '{8'h59, 8'h59, 8'h23, 8'h31, 8'h12, 8'h99};

  function automatic logic [7:0] bcd_next(input logic [7:0] v,
                                          input logic [7:0] lo,
                                          input logic [7:0] hi);
    logic [7:0] r;
    if (v >= hi)
      r = lo;
    else if (v[3:0] >= 4'd9)
      r = {v[7:4] + 4'd1, 4'd0};
    else
      r = {v[7:4], v[3:0] + 4'd1};
    return r;
  endfunction

  // [0],[1] synchroniser stages, [2] previous synchronised value for edges
  logic [2:0]    cs_q, wr_q, rd_q;
  logic [1:0]    aod_q;
  logic [7:0]    din1_q, din2_q;
  logic [2:0]    vld_q;
  logic          wr_arm_q, rd_arm_q;
  logic [7:0]    addr_q, dout_q;
  logic          oe_q, tick_q, run_q, pend_q;
  logic [CW-1:0] cnt_q;
  logic [7:0]    tm_q [6];
  logic [7:0]    tm_d [6];
  logic [5:0]    carry;

  logic       sel, wr_rise, rd_fall, rd_rise, cs_rise;
  logic       addr_wr, data_wr, rd_snap;
  logic       is_ctrl, is_tm, wr_hit, wrap, inc_go;
  logic [2:0] tm_idx;
  logic [7:0] rd_val;

  // A strobe only counts once it has been seen high after reset, so a
  // strobe held low across reset release needs a full high/low cycle.
  assign sel     = ~cs_q[1];
  assign wr_rise = wr_arm_q & wr_q[1] & ~wr_q[2];
  assign rd_fall = rd_arm_q & ~rd_q[1] & rd_q[2];
  assign rd_rise = rd_arm_q & rd_q[1] & ~rd_q[2];
  assign cs_rise = vld_q[2] & cs_q[1] & ~cs_q[2];

  assign addr_wr = wr_rise & sel & ~aod_q[1];
  assign data_wr = wr_rise & sel & aod_q[1];
  assign rd_snap = rd_fall & sel & aod_q[1];

  assign is_ctrl = (addr_q == 8'h20);
  assign is_tm   = (addr_q >= 8'h21) && (addr_q <= 8'h26);
  assign tm_idx  = addr_q[2:0] - 3'd1;
  assign wr_hit  = data_wr & (is_ctrl | is_tm);

  // A write commit wins the cycle; the increment slips one cycle via pend_q
  assign wrap     = run_q & (cnt_q == CNT_LAST);
  assign inc_go   = (wrap | pend_q) & ~wr_hit;
  assign carry[0] = inc_go;

  always_comb begin
    rd_val = 8'h00;
    if (is_ctrl)
      rd_val = {7'd0, run_q};
    else if (is_tm)
      rd_val = tm_q[tm_idx];
  end

  for (genvar gi = 0; gi < 6; gi++) begin : g_tm
    assign tm_d[gi] = carry[gi] ? bcd_next(tm_q[gi], TM_LO[gi], TM_HI[gi]) : tm_q[gi];
    if (gi < 5) begin : g_carry
      assign carry[gi+1] = carry[gi] & (tm_q[gi] >= TM_HI[gi]);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cs_q     <= 3'b111;
      wr_q     <= 3'b111;
      rd_q     <= 3'b111;
      aod_q    <= 2'b00;
      din1_q   <= 8'h00;
      din2_q   <= 8'h00;
      vld_q    <= 3'b000;
      wr_arm_q <= 1'b0;
      rd_arm_q <= 1'b0;
      addr_q   <= 8'h00;
      dout_q   <= 8'h00;
      oe_q     <= 1'b0;
      tick_q   <= 1'b0;
      run_q    <= 1'b1;
      pend_q   <= 1'b0;
      cnt_q    <= '0;
      for (int i = 0; i < 6; i++) tm_q[i] <= TM_LO[i];
    end else begin
      cs_q     <= {cs_q[1:0], ChipSelect};
      wr_q     <= {wr_q[1:0], Write};
      rd_q     <= {rd_q[1:0], Read};
      aod_q    <= {aod_q[0], AoD};
      din1_q   <= data_in;
      din2_q   <= din1_q;
      vld_q    <= {vld_q[1:0], 1'b1};
      wr_arm_q <= wr_arm_q | (vld_q[2] & wr_q[2]);
      rd_arm_q <= rd_arm_q | (vld_q[2] & rd_q[2]);

      for (int i = 0; i < 6; i++) tm_q[i] <= tm_d[i];
      if (wr_hit && is_tm)
        tm_q[tm_idx] <= din2_q;
      if (wr_hit && is_ctrl)
        run_q <= din2_q[0];
      if (addr_wr)
        addr_q <= din2_q;

      if (run_q)
        cnt_q <= wrap ? '0 : cnt_q + 1'b1;
      tick_q <= wrap;
      pend_q <= (wrap | pend_q) & wr_hit;

      if (rd_snap) begin
        dout_q <= rd_val;
        oe_q   <= 1'b1;
      end else if (rd_rise | cs_rise) begin
        oe_q <= 1'b0;
      end
    end
  end

  assign data_out = dout_q;
  assign data_oe  = oe_q;
  assign tick     = tick_q;

endmodule

// File: tb/tb_rtc_bus_responder.sv
// Directed bench for rtc_bus_responder with a 10-cycle seconds prescaler;
// bus transactions are driven on the falling clock edge and sampled there.
module tb_rtc_bus_responder;

  localparam int TDIV = 10;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       cs_n = 1'b1, wr_n = 1'b1, rd_n = 1'b1, aod = 1'b0;
  logic [7:0] din = 8'h00;
  logic [7:0] dout;
  logic       oe, tick;

  int cyc = 0;
  int vectors = 0;
  int miscompares = 0;
  int c, t, n;

  rtc_bus_responder #(.TICK_DIV(TDIV)) dut (
    .clk       (clk),
    .reset     (reset),
    .ChipSelect(cs_n),
    .Write     (wr_n),
    .Read      (rd_n),
    .AoD       (aod),
    .data_in   (din),
    .data_out  (dout),
    .data_oe   (oe),
    .tick      (tick)
  );

  always #5 clk = ~clk;

  // Edges since the last edge that sampled reset high
  always @(posedge clk) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int k);
    repeat (k) @(negedge clk);
  endtask

  function automatic logic [7:0] to_bcd(input int v);
    return 8'(((v / 10) * 16) + (v % 10));
  endfunction

  task automatic set_addr(input logic [7:0] a);
    cs_n = 1'b0; aod = 1'b0; din = a; wr_n = 1'b0;
    step(3);
    wr_n = 1'b1;
    step(3);
  endtask

  task automatic do_write(input logic [7:0] d);
    cs_n = 1'b0; aod = 1'b1; din = d; wr_n = 1'b0;
    step(3);
    wr_n = 1'b1;
    step(3);
  endtask

  // Read fall sampled at c+1 -> data_oe up after c+3; rise likewise clears 2 edges later
  task automatic do_read(input logic [7:0] exp, input string tag);
    cs_n = 1'b0; aod = 1'b1; rd_n = 1'b0;
    step(2);
    check({tag, "_oe_early"}, oe, 1'b0);
    step(1);
    check({tag, "_oe"}, oe, 1'b1);
    check({tag, "_data"}, dout, exp);
    rd_n = 1'b1;
    step(2);
    check({tag, "_oe_hold"}, oe, 1'b1);
    step(1);
    check({tag, "_oe_clr"}, oe, 1'b0);
  endtask

  task automatic wait_tick(output int at);
    int k;
    k = 0;
    while (tick !== 1'b1 && k < 40) begin
      step(1);
      k++;
    end
    check("tick_seen", tick, 1'b1);
    at = cyc;
  endtask

  initial begin
    // Reset values and first tick
    reset = 1'b1;
    step(3);
    reset = 1'b0;
    check("rst_oe", oe, 1'b0);
    check("rst_dout", dout, 8'h00);
    check("rst_tick", tick, 1'b0);
    wait_tick(t);
    check("first_tick_cycle", t, 10);
    step(1);
    check("tick_width", tick, 1'b0);

    // Seconds read live: snapshot at edge c+3 sees ticks up to edge c+2
    set_addr(8'h21);
    c = cyc;
    do_read(to_bcd((c + 2) / TDIV), "rst_sec");
    set_addr(8'h24); do_read(8'h01, "rst_day");
    set_addr(8'h25); do_read(8'h01, "rst_mon");
    set_addr(8'h20); do_read(8'h01, "rst_ctrl");

    // Hours write and read back
    set_addr(8'h23); do_write(8'h17);
    set_addr(8'h23); do_read(8'h17, "hour_rw");

    // Full calendar rollover on a single tick
    set_addr(8'h20); do_write(8'h00);
    set_addr(8'h21); do_write(8'h59);
    set_addr(8'h22); do_write(8'h59);
    set_addr(8'h23); do_write(8'h23);
    set_addr(8'h24); do_write(8'h31);
    set_addr(8'h25); do_write(8'h12);
    set_addr(8'h26); do_write(8'h99);
    set_addr(8'h20); do_write(8'h01);
    wait_tick(t);
    do_write(8'h00);
    set_addr(8'h21); do_read(8'h00, "roll_sec");
    set_addr(8'h22); do_read(8'h00, "roll_min");
    set_addr(8'h23); do_read(8'h00, "roll_hour");
    set_addr(8'h24); do_read(8'h01, "roll_day");
    set_addr(8'h25); do_read(8'h01, "roll_mon");
    set_addr(8'h26); do_read(8'h00, "roll_year");

    // Seconds write landing on the prescaler wrap at t+20
    set_addr(8'h20); do_write(8'h01);
    wait_tick(t);
    set_addr(8'h21);
    step(t + 14 - cyc);
    do_write(8'h59);
    check("collide_tick", tick, 1'b1);
    step(1);
    check("collide_tick_width", tick, 1'b0);
    // 59 -> deferred 00 (min 01) -> tick at t+30 -> 01; stopped at t+33
    set_addr(8'h20); do_write(8'h00);
    set_addr(8'h21); do_read(8'h01, "collide_sec");
    set_addr(8'h22); do_read(8'h01, "collide_min");

    // Stopped clock, then resume
    set_addr(8'h20); do_write(8'h00);
    n = 0;
    repeat (50) begin
      step(1);
      if (tick) n++;
    end
    check("stopped_ticks", n, 0);
    set_addr(8'h21); do_read(8'h01, "stopped_sec");
    set_addr(8'h20); do_write(8'h01);
    wait_tick(t);
    n = 0;
    repeat (9) begin
      step(1);
      if (tick) n++;
    end
    check("resume_gap", n, 0);
    step(1);
    check("resume_period", tick, 1'b1);

    // Reset in the middle of a read
    set_addr(8'h24);
    cs_n = 1'b0; aod = 1'b1; rd_n = 1'b0;
    step(3);
    check("pre_rst_oe", oe, 1'b1);
    check("pre_rst_data", dout, 8'h01);
    reset = 1'b1;
    step(1);
    check("mid_rst_oe", oe, 1'b0);
    check("mid_rst_dout", dout, 8'h00);
    step(2);
    reset = 1'b0;
    n = 0;
    repeat (12) begin
      step(1);
      if (oe) n++;
    end
    check("held_read_ignored", n, 0);
    rd_n = 1'b1;
    step(4);
    do_read(8'h00, "addr_after_rst");
    set_addr(8'h55); do_read(8'h00, "unmapped");
    set_addr(8'h20); do_read(8'h01, "ctrl_after_rst");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
